// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: operation-mode codes, FSM states
// and the legal-mode decode used at accept time.
package shift_pkg;

  localparam logic [2:0] OPM2_SLL = 3'b001;
  localparam logic [2:0] OPM2_SR  = 3'b101;
  localparam logic [1:0] OPM1_LOG = 2'b00;
  localparam logic [1:0] OPM1_ARI = 2'b01;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // Only SLL, SRL and SRA exist; every other mode pair is reported as an error.
  function automatic logic mode_legal(input logic [2:0] m2, input logic [1:0] m1);
    return ((m2 == OPM2_SLL) && (m1 == OPM1_LOG)) ||
           ((m2 == OPM2_SR) && ((m1 == OPM1_LOG) || (m1 == OPM1_ARI)));
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by 'amount' positions left or
// right, filling vacated right-shift positions with 'fill'.
module shift_step #(
  parameter int XLEN = 32,
  parameter int SW   = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] value,
  input  logic [SW-1:0]   amount,
  input  logic            left,
  input  logic            fill,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = value >> amount;
    if (left) begin
      result = value << amount;
    end else if (fill) begin
      // Inverting around a logical shift brings in ones instead of zeros.
      result = ~((~value) >> amount);
    end
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative shifter: captures an operand on start, shifts it up to STEP
// positions per cycle, then pulses done with the result (or err on a bad mode).
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            start,
  input  logic [1:0]      op_mode1,
  input  logic [2:0]      op_mode2,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] res
);

  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  // Handshake: start is sampled only while idle (busy=0, which includes the
  // cycle done=1); busy covers every SHIFT cycle; done/err pulse for exactly one
  // cycle; res keeps its value until a later operation completes.

  state_t          state, state_d;
  logic [XLEN-1:0] acc;
  logic [SW-1:0]   rem;
  logic [SW-1:0]   amt;
  logic            left_q;
  logic            fill_q;
  logic            illegal_q;
  logic            accept;
  logic            finish;
  logic            step_en;
  logic [XLEN-1:0] step_out;
  logic [SW-1:0]   shamt;
  logic            unused_op2_hi;

  assign shamt         = op2[SW-1:0];
  assign unused_op2_hi = ^op2[XLEN-1:SW];
  assign amt           = (rem < STEP_W) ? rem : STEP_W;

  shift_step #(
    .XLEN(XLEN),
    .SW  (SW)
  ) u_step (
    .value (acc),
    .amount(amt),
    .left  (left_q),
    .fill  (fill_q),
    .result(step_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    finish  = 1'b0;
    step_en = 1'b0;
    busy    = (state == S_SHIFT);
    case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (rem == '0) begin
          finish  = 1'b1;
          state_d = S_IDLE;
        end else begin
          step_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      rem       <= '0;
      left_q    <= 1'b0;
      fill_q    <= 1'b0;
      illegal_q <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      res       <= '0;
    end else begin
      done <= finish;
      err  <= finish & illegal_q;
      if (accept) begin
        acc       <= op1;
        // An illegal mode skips straight to completion on the next edge.
        rem       <= mode_legal(op_mode2, op_mode1) ? shamt : '0;
        left_q    <= (op_mode2 == OPM2_SLL);
        fill_q    <= (op_mode1 == OPM1_ARI) & op1[XLEN-1];
        illegal_q <= ~mode_legal(op_mode2, op_mode1);
      end else if (step_en) begin
        acc <= step_out;
        rem <= rem - amt;
      end
      if (finish) begin
        res <= illegal_q ? '0 : acc;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq: one STEP=4 and one STEP=1 instance driven
// in lockstep from a vector table, plus reset and back-to-back sequences.
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        start = 1'b0;
  logic [1:0]  op_mode1 = '0;
  logic [2:0]  op_mode2 = '0;

  logic        busy4, done4, err4;
  logic [31:0] res4;
  logic        busy1, done1, err1;
  logic [31:0] res1;

  always #5 clk = ~clk;

  shift_unit_seq #(.XLEN(32), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .op1(op1), .op2(op2), .start(start),
    .op_mode1(op_mode1), .op_mode2(op_mode2),
    .busy(busy4), .done(done4), .err(err4), .res(res4)
  );

  shift_unit_seq #(.XLEN(32), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .op1(op1), .op2(op2), .start(start),
    .op_mode1(op_mode1), .op_mode2(op_mode2),
    .busy(busy1), .done(done1), .err(err1), .res(res1)
  );

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  m1;
    logic [2:0]  m2;
    logic [31:0] exp_res;
    logic        exp_err;
    int          lat4;
    int          lat1;
    int          poke;
  } vec_t;

  vec_t        vecs[12];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents an operation and returns just after its accept edge.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m1, input logic [2:0] m2);
    @(negedge clk);
    op1 = a; op2 = b; op_mode1 = m1; op_mode2 = m2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          n = 0;
    int          lat4 = -1;
    int          lat1 = -1;
    int          p4 = 0;
    int          p1 = 0;
    logic [31:0] r4 = '0;
    logic [31:0] r1 = '0;
    logic        e4 = 1'b0;
    logic        e1 = 1'b0;
    logic [31:0] e;
    exp_q.push_back(v.exp_res);
    drive(v.op1, v.op2, v.m1, v.m2);
    check($sformatf("v%0d busy4 after accept", idx), 32'(busy4), 32'd1);
    while ((lat4 < 0 || lat1 < 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == v.poke + 1) start = 1'b0;
      if ((busy4 && done4) || (busy1 && done1))
        check($sformatf("v%0d busy/done overlap", idx), 32'd1, 32'd0);
      if (done4) begin
        p4++;
        if (lat4 < 0) begin lat4 = n; r4 = res4; e4 = err4; end
      end
      if (done1) begin
        p1++;
        if (lat1 < 0) begin lat1 = n; r1 = res1; e1 = err1; end
      end
      if (n == v.poke) begin
        @(negedge clk);
        op1 = 32'hFFFF_FFFF; op2 = 32'd3; start = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (done4) p4++;
    if (done1) p1++;
    e = exp_q.pop_front();
    check($sformatf("v%0d res4", idx), r4, e);
    check($sformatf("v%0d res1", idx), r1, e);
    check($sformatf("v%0d res4 held", idx), res4, e);
    check($sformatf("v%0d err4", idx), 32'(e4), 32'(v.exp_err));
    check($sformatf("v%0d err1", idx), 32'(e1), 32'(v.exp_err));
    check($sformatf("v%0d lat4", idx), 32'(lat4), 32'(v.lat4));
    check($sformatf("v%0d lat1", idx), 32'(lat1), 32'(v.lat1));
    check($sformatf("v%0d done4 pulses", idx), 32'(p4), 32'd1);
    check($sformatf("v%0d done1 pulses", idx), 32'(p1), 32'd1);
  endtask

  initial begin
    int n;
    //            op1           op2           m1     m2      exp_res       err  l4  l1  poke
    vecs[0]  = '{32'h0000_0001, 32'd31,       2'b00, 3'b001, 32'h8000_0000, 1'b0, 9, 32, -1};
    vecs[1]  = '{32'h8000_0000, 32'd4,        2'b01, 3'b101, 32'hF800_0000, 1'b0, 2, 5,  -1};
    vecs[2]  = '{32'h8000_0000, 32'd4,        2'b00, 3'b101, 32'h0800_0000, 1'b0, 2, 5,  -1};
    vecs[3]  = '{32'h1234_5678, 32'hFFFF_FFE0, 2'b00, 3'b001, 32'h1234_5678, 1'b0, 1, 1,  -1};
    vecs[4]  = '{32'hDEAD_BEEF, 32'd4,        2'b00, 3'b010, 32'h0000_0000, 1'b1, 1, 1,  -1};
    vecs[5]  = '{32'h8F00_F00F, 32'd7,        2'b01, 3'b101, 32'hFF1E_01E0, 1'b0, 3, 8,  -1};
    vecs[6]  = '{32'hDEAD_BEEF, 32'd8,        2'b00, 3'b101, 32'h00DE_ADBE, 1'b0, 3, 9,  -1};
    vecs[7]  = '{32'hDEAD_BEEF, 32'h0000_0025, 2'b00, 3'b001, 32'hD5B7_DDE0, 1'b0, 3, 6,  -1};
    vecs[8]  = '{32'hDEAD_BEEF, 32'd3,        2'b01, 3'b001, 32'h0000_0000, 1'b1, 1, 1,  -1};
    vecs[9]  = '{32'h4000_0000, 32'd30,       2'b01, 3'b101, 32'h0000_0001, 1'b0, 9, 31, -1};
    vecs[10] = '{32'h8000_0000, 32'd2,        2'b10, 3'b101, 32'h0000_0000, 1'b1, 1, 1,  -1};
    vecs[11] = '{32'h0000_0001, 32'd31,       2'b00, 3'b001, 32'h8000_0000, 1'b0, 9, 32, 3};

    #1;
    check("reset busy4", 32'(busy4), 32'd0);
    check("reset done4", 32'(done4), 32'd0);
    check("reset err4",  32'(err4),  32'd0);
    check("reset res4",  res4,       32'd0);
    check("reset busy1", 32'(busy1), 32'd0);
    check("reset res1",  res1,       32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset in the middle of a long shift abandons it silently.
    drive(32'h0000_0001, 32'd31, 2'b00, 3'b001);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset busy4", 32'(busy4), 32'd0);
    check("midreset busy1", 32'(busy1), 32'd0);
    check("midreset res4",  res4,       32'd0);
    check("midreset res1",  res1,       32'd0);
    check("midreset done4", 32'(done4), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("midreset no done", 32'(done4 | done1), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post reset idle", 32'(busy4 | busy1 | done4 | done1), 32'd0);
    run_vec('{32'h0000_0003, 32'd1, 2'b00, 3'b001, 32'h0000_0006, 1'b0, 2, 2, -1}, 12);

    // start held high through done: the second operation is taken on the done cycle.
    drive(32'h0000_00F0, 32'd4, 2'b00, 3'b101);
    start = 1'b1;
    op1 = 32'h0000_0001; op2 = 32'd2; op_mode1 = 2'b00; op_mode2 = 3'b001;
    n = 0;
    while (!done4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b first lat4", 32'(n), 32'd2);
    check("b2b first res4", res4, 32'h0000_000F);
    @(posedge clk);
    #1;
    check("b2b busy4 after re-accept", 32'(busy4), 32'd1);
    check("b2b done4 low after re-accept", 32'(done4), 32'd0);
    start = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("b2b second lat4", 32'(n), 32'd2);
    check("b2b second res4", res4, 32'h0000_0004);
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
